ch446_serial_tx: RTL
====================

Name: ch446_serial_tx

Overview:
MCU-side transmitter for the CH446Q-compatible serial key-matrix link (DAT/SK/STB) that feeds the ZX bus keyboard emulation.
- Accepts key events (7-bit switch address plus on/off) over a valid/ready interface and buffers them in a small FIFO.
- Serialises each event as one CH446Q frame: 7 address bits MSB-first clocked on SK rising edges, then the switch state on DAT latched by a high STB pulse.
- Runs on the MCU/bridge system clock; SK, DAT and STB are registered outputs.

Parameters:
CLK_DIV, 4, system clocks per SK half-period and per setup/hold interval (min 1)
STB_CYCLES, 2, STB high width in system clocks (min 1)
FIFO_DEPTH, 8, event FIFO entries (power of two, min 2)

Ports:
clk  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
ev_valid  input  1  event offered
ev_ready  output  1  FIFO can accept event
ev_addr  input  7  {AY[2:0],AX[3:0]}; AX=8 selects special keys (AY 5=MAGIC, 6=RESET, 7=PAUSE)
ev_on  input  1  1 = switch on (key pressed / special asserted), 0 = off
release_all  input  1  request full matrix release sweep (only with optional feature; otherwise ignored)
DAT  output  1  serial data / switch state
SK  output  1  serial clock; receiver shifts on rising edge
STB  output  1  strobe, active high
busy  output  1  frame in progress or FIFO non-empty
fifo_level  output  $clog2(FIFO_DEPTH)+1  current entry count

Behaviour:
- Reset (rst_in=0, async): DAT=0, SK=0, STB=0, busy=0, fifo_level=0, ev_ready=0 while asserted; FIFO and FSM cleared. ev_ready=1 from the first clock after release.
- Reset mid-frame: outputs drop immediately. No STB is issued, so the receiver's matrix is untouched; its stale shift register is overwritten by the next full frame.
- Handshake: an event is accepted when ev_valid & ev_ready at a clk rising edge.
  - ev_ready = !full.
  - Push to a full FIFO is impossible; a pop in the same cycle does not raise ev_ready until the next cycle.
- FIFO: first-word-fall-through; entry = {ev_addr, ev_on} (8 bits); fifo_level updates the cycle after push/pop; a simultaneous push and pop leaves the level unchanged.
- FSM states: IDLE, BIT_LO, BIT_HI, DATA_SETUP, STROBE, HOLD.
  - IDLE: if FIFO non-empty, pop into frame register; bit index=6; go BIT_LO. SK=0, STB=0, DAT=0.
  - BIT_LO: DAT=frame_addr[bit]; SK=0 for CLK_DIV clocks; then BIT_HI.
  - BIT_HI: SK=1, DAT stable, for CLK_DIV clocks. If bit>0: decrement bit, go BIT_LO. Else go DATA_SETUP.
  - DATA_SETUP: SK=0, DAT=frame_on for CLK_DIV clocks.
  - STROBE: STB=1 for STB_CYCLES clocks; DAT held.
  - HOLD: STB=0, DAT held for CLK_DIV clocks; then IDLE, with DAT returning to 0.
- Bit order: AY2, AY1, AY0, AX3, AX2, AX1, AX0. DAT changes only while SK=0, never while STB=1.
- Frame length: 14*CLK_DIV + CLK_DIV + STB_CYCLES + CLK_DIV clocks. Defaults give 66 clocks, plus 1 IDLE clock between back-to-back frames.
- Latency: first SK rise occurs CLK_DIV+1 clocks after the pop cycle.
- busy = (state != IDLE) | (fifo_level != 0).
- No address validation: out-of-range codes (AX 9..15, or AX=8 with AY<5) are transmitted verbatim; the receiver ignores or misroutes them, which is the caller's responsibility.

Optional Feature:
Macro CH446_RELEASE_ALL_EN.
- Defined: a rising edge on release_all (edge-detected) arms a sweep generator. The generator injects 43 off-events in order: AY 0..4 × AX 0..7 (AY outer, AX inner), then AX=8 with AY=5, 6, 7.
  - While the sweep is active, ev_ready=0 and external events are blocked; the sweep pushes one event per clock whenever the FIFO is not full.
  - Events already in the FIFO are sent first.
  - A new release_all edge during an active sweep is ignored.
  - Reset aborts the sweep.
- Undefined: release_all is unused and ev_ready = !full only.

Decomposition:
- Package hidman_zx_pkg holds:
  - CH446_ADDR_W=7
  - AX_SPECIAL=4'd8, AY_MAGIC=3'd5, AY_RESET=3'd6, AY_PAUSE=3'd7
  - ZX_KEY_ROWS=8, ZX_KEY_COLS=5
  - the FSM state enum
  - the 8-bit event struct {addr, on}
- One sub-module, hidman_event_fifo: parameterised synchronous FWFT FIFO with the same async active-low reset.

Test Plan:
- CLK_DIV=4, STB_CYCLES=2. Push addr=0x24, on=1:
  - DAT sampled at the 7 SK rises = 0,1,0,0,1,0,0.
  - DAT=1 during the single 2-clock STB pulse.
  - Frame takes 66 clocks; first SK rise 5 clocks after pop.
- Push 9 events back-to-back with FIFO_DEPTH=8:
  - ev_ready falls after the FIFO fills, reaching fifo_level=8.
  - All 9 frames are emitted in order, 67 clocks apart; no event is lost.
- Push addr=0x68 (AX=8, AY=6), on=1, then on=0: bits 1,1,0,1,0,0,0 for each frame; STB-time DAT is 1 then 0.
- Assert rst_in low at frame clock 20:
  - SK/DAT/STB go 0 asynchronously; no STB is seen; fifo_level=0.
  - After release, a fresh event frames correctly.
- Across all scenarios, check the invariants: DAT never toggles while SK=1 or STB=1, and STB never overlaps SK=1.
- With CH446_RELEASE_ALL_EN, pulse release_all with 2 events queued:
  - 2 queued frames go out first, then 43 off-frames, addresses 0x00..0x07, 0x10..0x47, 0x58, 0x68, 0x78.
  - ev_ready=0 throughout the sweep.

Source files
------------

// File: rtl/hidman_zx_pkg.sv
// hidman_zx_pkg: shared types and constants for the CH446Q serial key-matrix
// transmitter.
//   - CH446Q address width and ZX special-key codes (AX=8 column)
//   - ZX keyboard matrix geometry used by the release-all sweep
//   - transmitter FSM state enum and the 8-bit key event struct
//   - sweep_addr(): maps a sweep index to the switch address it releases
package hidman_zx_pkg;

   localparam int CH446_ADDR_W = 7;

   localparam logic [3:0] AX_SPECIAL = 4'd8;
   localparam logic [2:0] AY_MAGIC   = 3'd5;
   localparam logic [2:0] AY_RESET   = 3'd6;
   localparam logic [2:0] AY_PAUSE   = 3'd7;

   localparam int ZX_KEY_ROWS = 8;
   localparam int ZX_KEY_COLS = 5;

   // Ordinary key switches, then the three special switches.
   localparam int SWEEP_MATRIX = ZX_KEY_ROWS * ZX_KEY_COLS;
   localparam int SWEEP_LEN    = SWEEP_MATRIX + 3;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_BIT_LO     = 3'd1,
      ST_BIT_HI     = 3'd2,
      ST_DATA_SETUP = 3'd3,
      ST_STROBE     = 3'd4,
      ST_HOLD       = 3'd5
   } tx_state_e;

   typedef struct packed {
      logic [CH446_ADDR_W-1:0] addr;
      logic                    on;
   } ch446_event_t;

   // Index 0..39 walks AY 0..4 (outer) x AX 0..7 (inner); 40..42 are the
   // special switches MAGIC, RESET, PAUSE on the AX=8 column.
   function automatic logic [CH446_ADDR_W-1:0] sweep_addr(input logic [5:0] idx);
      logic [CH446_ADDR_W-1:0] a;
      logic [5:0]              off;
      a   = 7'd0;
      off = idx - 6'(SWEEP_MATRIX);
      if (idx < 6'(SWEEP_MATRIX)) begin
         a = {idx[5:3], 1'b0, idx[2:0]};
      end else begin
         case (off[1:0])
            2'd0:    a = {AY_MAGIC, AX_SPECIAL};
            2'd1:    a = {AY_RESET, AX_SPECIAL};
            default: a = {AY_PAUSE, AX_SPECIAL};
         endcase
      end
      return a;
   endfunction

endpackage

// File: rtl/hidman_event_fifo.sv
// hidman_event_fifo: synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst_in   clock, asynchronous active-low reset (clears pointers/count)
//   push, push_data   write request and data (ignored when full)
//   pop, pop_data     read request (ignored when empty); pop_data shows the
//                     head entry whenever the FIFO is non-empty
//   full, empty, level   status derived from the registered entry count
module hidman_event_fifo
   import hidman_zx_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_in,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_r == FULL_CNT);
   assign empty     = (count_r == (PTR_W+1)'(0));
   assign level     = count_r;
   assign pop_data  = mem_r[rd_ptr_r];
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= (PTR_W+1)'(0);
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (PTR_W+1)'(1);
            2'b01:   count_r <= count_r - (PTR_W+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/ch446_serial_tx.sv
// ch446_serial_tx: MCU-side CH446Q serial transmitter (DAT/SK/STB).
// Key events {addr, on} are queued in an FWFT FIFO and sent one frame each:
// 7 address bits MSB-first on SK rising edges, then the switch state on DAT
// latched by a high STB pulse.
// Ports:
//   clk, rst_in          system clock, asynchronous active-low reset
//   ev_valid/ev_ready    event handshake; ev_addr = {AY[2:0],AX[3:0]}, ev_on
//   release_all          full-matrix release request (optional feature)
//   DAT, SK, STB         registered serial link outputs
//   busy, fifo_level     frame in progress / queued entries
// Optional feature macro: CH446_RELEASE_ALL_EN (release_all sweep generator).
module ch446_serial_tx
   import hidman_zx_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int STB_CYCLES = 2,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_in,
   input  logic                          ev_valid,
   output logic                          ev_ready,
   input  logic [6:0]                    ev_addr,
   input  logic                          ev_on,
   input  logic                          release_all,
   output logic                          DAT,
   output logic                          SK,
   output logic                          STB,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int          LVL_W    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0] STB_LAST = 16'(STB_CYCLES - 1);

   tx_state_e    state_r;
   logic [15:0]  cnt_r;
   logic [2:0]   bit_r;
   ch446_event_t frame_r;
   logic         dat_r;
   logic         sk_r;
   logic         stb_r;
   logic         ready_en_r;
   logic         sweep_active_s;

   logic         fifo_push_s;
   ch446_event_t fifo_din_s;
   logic         fifo_pop_s;
   ch446_event_t fifo_dout_s;
   logic         fifo_full_s;
   logic         fifo_empty_s;

   assign DAT        = dat_r;
   assign SK         = sk_r;
   assign STB        = stb_r;
   assign ev_ready   = ready_en_r & ~fifo_full_s & ~sweep_active_s;
   assign busy       = (state_r != ST_IDLE) | (fifo_level != LVL_W'(0));
   assign fifo_pop_s = (state_r == ST_IDLE) & ~fifo_empty_s;

   // Holds ev_ready low during reset and for the cycle it is released in.
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         ready_en_r <= 1'b0;
      end else begin
         ready_en_r <= 1'b1;
      end
   end

`ifdef CH446_RELEASE_ALL_EN
   logic       rel_prev_r;
   logic       sweep_active_r;
   logic [5:0] sweep_idx_r;

   assign sweep_active_s = sweep_active_r;

   // Sweep generator: armed by a release_all rising edge, emits one off-event
   // per cycle while the FIFO has room; further edges are ignored meanwhile.
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         rel_prev_r     <= 1'b0;
         sweep_active_r <= 1'b0;
         sweep_idx_r    <= 6'd0;
      end else begin
         rel_prev_r <= release_all;
         if (sweep_active_r) begin
            if (!fifo_full_s) begin
               sweep_idx_r <= sweep_idx_r + 6'd1;
               if (sweep_idx_r == 6'(SWEEP_LEN - 1)) begin
                  sweep_active_r <= 1'b0;
               end
            end
         end else if (release_all && !rel_prev_r) begin
            sweep_active_r <= 1'b1;
            sweep_idx_r    <= 6'd0;
         end
      end
   end

   // FIFO write source: the sweep owns the FIFO input while it runs.
   always_comb begin
      fifo_push_s = 1'b0;
      fifo_din_s  = 8'h00;
      if (sweep_active_r) begin
         fifo_push_s = ~fifo_full_s;
         fifo_din_s  = {sweep_addr(sweep_idx_r), 1'b0};
      end else begin
         fifo_push_s = ev_valid & ev_ready;
         fifo_din_s  = {ev_addr, ev_on};
      end
   end
`else
   logic unused_release_all;

   assign unused_release_all = release_all;
   assign sweep_active_s     = 1'b0;

   // FIFO write source: external events only.
   always_comb begin
      fifo_push_s = ev_valid & ev_ready;
      fifo_din_s  = {ev_addr, ev_on};
   end
`endif

   hidman_event_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_in    (rst_in),
      .push      (fifo_push_s),
      .push_data (fifo_din_s),
      .pop       (fifo_pop_s),
      .pop_data  (fifo_dout_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .level     (fifo_level)
   );

   // Frame sequencer. Outputs are registered together with the state they
   // belong to, so DAT only moves on the same edge SK falls (or in IDLE).
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         state_r <= ST_IDLE;
         cnt_r   <= 16'd0;
         bit_r   <= 3'd0;
         frame_r <= 8'h00;
         dat_r   <= 1'b0;
         sk_r    <= 1'b0;
         stb_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               sk_r  <= 1'b0;
               stb_r <= 1'b0;
               cnt_r <= 16'd0;
               if (!fifo_empty_s) begin
                  frame_r <= fifo_dout_s;
                  bit_r   <= 3'd6;
                  dat_r   <= fifo_dout_s.addr[6];
                  state_r <= ST_BIT_LO;
               end else begin
                  dat_r <= 1'b0;
               end
            end
            ST_BIT_LO: begin
               if (cnt_r == DIV_LAST) begin
                  cnt_r   <= 16'd0;
                  sk_r    <= 1'b1;
                  state_r <= ST_BIT_HI;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            ST_BIT_HI: begin
               if (cnt_r == DIV_LAST) begin
                  cnt_r <= 16'd0;
                  sk_r  <= 1'b0;
                  if (bit_r != 3'd0) begin
                     bit_r   <= bit_r - 3'd1;
                     dat_r   <= frame_r.addr[bit_r - 3'd1];
                     state_r <= ST_BIT_LO;
                  end else begin
                     dat_r   <= frame_r.on;
                     state_r <= ST_DATA_SETUP;
                  end
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            ST_DATA_SETUP: begin
               if (cnt_r == DIV_LAST) begin
                  cnt_r   <= 16'd0;
                  stb_r   <= 1'b1;
                  state_r <= ST_STROBE;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            ST_STROBE: begin
               if (cnt_r == STB_LAST) begin
                  cnt_r   <= 16'd0;
                  stb_r   <= 1'b0;
                  state_r <= ST_HOLD;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            ST_HOLD: begin
               if (cnt_r == DIV_LAST) begin
                  cnt_r   <= 16'd0;
                  dat_r   <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            default: begin
               cnt_r   <= 16'd0;
               dat_r   <= 1'b0;
               sk_r    <= 1'b0;
               stb_r   <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
